// File: rtl/laplace_pkg.sv
// Shared constants, FSM encoding and the cross-window fetch-offset table
// for the Laplace scan controller.
package laplace_pkg;

  localparam int IMG_W   = 512;
  localparam int ROWS    = 510;
  localparam int COLS    = 510;
  localparam int ADDR_W  = 18;
  localparam int PIX_W   = 8;
  localparam int CRD_W   = 9;
  localparam int K_W     = 3;
  localparam int FETCH_N = 5;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPT,
    CALC,
    EMIT,
    DONE
  } state_t;

  typedef struct packed {
    logic [1:0] dx;
    logic [1:0] dy;
  } fetch_off_t;

  // Window positions relative to (col, row) of the output pixel, fetch order b,d,e,f,h.
  function automatic fetch_off_t fetch_off(input logic [K_W-1:0] k);
    fetch_off_t off;
    case (k)
      3'd0:    off = '{dx: 2'd1, dy: 2'd0};
      3'd1:    off = '{dx: 2'd0, dy: 2'd1};
      3'd2:    off = '{dx: 2'd1, dy: 2'd1};
      3'd3:    off = '{dx: 2'd2, dy: 2'd1};
      default: off = '{dx: 2'd1, dy: 2'd2};
    endcase
    return off;
  endfunction

endpackage

// File: rtl/laplace_addr_gen.sv
// Combinational image-memory address for window element k of output pixel (row, col).
module laplace_addr_gen
  import laplace_pkg::*;
#(
  parameter int IMG_W = laplace_pkg::IMG_W
) (
  input  logic [CRD_W-1:0]  row,
  input  logic [CRD_W-1:0]  col,
  input  logic [K_W-1:0]    k,
  output logic [ADDR_W-1:0] addr
);

  fetch_off_t off;

  // All operands widened to the full address width before the multiply.
  always_comb begin
    off  = fetch_off(k);
    addr = (ADDR_W'(row) + ADDR_W'(off.dy)) * ADDR_W'(IMG_W)
         + ADDR_W'(col) + ADDR_W'(off.dx);
  end

endmodule

// File: rtl/laplace_scan_ctrl.sv
// Raster-scan controller: fetches the 5-pixel cross window per output pixel,
// feeds the external Laplace datapath and emits results over valid/ready.
module laplace_scan_ctrl
  import laplace_pkg::*;
#(
  parameter int IMG_W = laplace_pkg::IMG_W,
  parameter int ROWS  = laplace_pkg::ROWS,
  parameter int COLS  = laplace_pkg::COLS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  win_b,
  output logic [PIX_W-1:0]  win_d,
  output logic [PIX_W-1:0]  win_e,
  output logic [PIX_W-1:0]  win_f,
  output logic [PIX_W-1:0]  win_h,
  input  logic [PIX_W-1:0]  filt_s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_pixel,
  output logic [CRD_W-1:0]  out_row,
  output logic [CRD_W-1:0]  out_col
);

  localparam logic [CRD_W-1:0] LAST_ROW = CRD_W'(ROWS - 1);
  localparam logic [CRD_W-1:0] LAST_COL = CRD_W'(COLS - 1);
  localparam logic [K_W-1:0]   LAST_K   = K_W'(FETCH_N - 1);

  state_t              state_q, state_d;
  logic [CRD_W-1:0]    row_q, row_d;
  logic [CRD_W-1:0]    col_q, col_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [ADDR_W-1:0]   addr_d;

  // Address is computed from the next-cycle coordinates so the registered
  // mem_addr lines up with the FETCH cycle that uses it.
  laplace_addr_gen #(
    .IMG_W (IMG_W)
  ) u_addr_gen (
    .row  (row_d),
    .col  (col_d),
    .k    (k_d),
    .addr (addr_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
        end
      end
      FETCH: begin
        if (k_q == LAST_K) begin
          state_d = CAPT;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      CAPT: state_d = CALC;
      CALC: state_d = EMIT;
      EMIT: begin
        if (out_ready) begin
          if (col_q < LAST_COL) begin
            col_d   = col_q + 1'b1;
            state_d = FETCH;
          end else if (row_q < LAST_ROW) begin
            col_d   = '0;
            row_d   = row_q + 1'b1;
            state_d = FETCH;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd    = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      FETCH: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
      end
      CAPT, CALC: busy = 1'b1;
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Read data arrives one cycle after its fetch: FETCH k=1..4 capture b..f, CAPT captures h.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      win_b     <= '0;
      win_d     <= '0;
      win_e     <= '0;
      win_f     <= '0;
      win_h     <= '0;
      out_pixel <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      mem_addr <= (state_d == FETCH) ? addr_d : '0;
      if (state_q == FETCH) begin
        case (k_q)
          3'd1:    win_b <= mem_rdata;
          3'd2:    win_d <= mem_rdata;
          3'd3:    win_e <= mem_rdata;
          3'd4:    win_f <= mem_rdata;
          default: ;
        endcase
      end
      if (state_q == CAPT) win_h <= mem_rdata;
      if (state_q == CALC) begin
        out_pixel <= filt_s;
        out_row   <= row_q;
        out_col   <= col_q;
      end
    end
  end

endmodule

// File: tb/tb_laplace_scan_ctrl.sv
// Scoreboard bench: 1-cycle memory model, approximate Laplace datapath and a
// coordinate-level reference model of the expected fetch and output streams.
module tb_laplace_scan_ctrl;
  import laplace_pkg::*;

  localparam int T_W = 512;
  localparam int T_R = 3;
  localparam int T_C = 6;
  localparam int IMG_WORDS = (T_R + 2) * T_W;
  localparam int DX [5] = '{1, 0, 1, 2, 1};
  localparam int DY [5] = '{0, 1, 1, 1, 2};

  typedef struct {
    int row;
    int col;
    int pix;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy, done, mem_rd, out_valid, out_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata;
  logic [PIX_W-1:0]  win_b, win_d, win_e, win_f, win_h, filt_s, out_pixel;
  logic [CRD_W-1:0]  out_row, out_col;

  logic [CRD_W-1:0]  ag_row, ag_col;
  logic [K_W-1:0]    ag_k;
  logic [ADDR_W-1:0] ag_addr;

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_hs     = 0;
  int   done_cnt    = 0;
  int   exp_done    = 0;
  int   ready_mode  = 0;
  bit   first_hs    = 1'b1;
  bit   mon_en      = 1'b0;
  int   addr_q [$];
  exp_t pix_q  [$];
  exp_t mon_e;

  always #5 clk = ~clk;

  laplace_scan_ctrl #(
    .IMG_W (T_W),
    .ROWS  (T_R),
    .COLS  (T_C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .win_b     (win_b),
    .win_d     (win_d),
    .win_e     (win_e),
    .win_f     (win_f),
    .win_h     (win_h),
    .filt_s    (filt_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_row   (out_row),
    .out_col   (out_col)
  );

  // Full-size address generator for the last-pixel boundary addresses.
  laplace_addr_gen u_agen_full (
    .row  (ag_row),
    .col  (ag_col),
    .k    (ag_k),
    .addr (ag_addr)
  );

  function automatic logic [7:0] lap(input int b, input int d, input int e,
                                     input int f, input int h);
    int s;
    s = 4 * e - b - d - f - h;
    if (s < 0) s = -s;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  assign filt_s = lap(int'(win_b), int'(win_d), int'(win_e), int'(win_f), int'(win_h));

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  function automatic int img(input int r, input int c);
    return int'(mem[r * T_W + c]);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctrl"}, 64'({busy, done, mem_rd, out_valid, mem_addr}), 64'd0);
    check({name, "_win"},  64'({win_b, win_d, win_e, win_f, win_h}), 64'd0);
    check({name, "_out"},  64'({out_pixel, out_row, out_col}), 64'd0);
  endtask

  task automatic push_frame();
    exp_t e;
    for (int r = 0; r < T_R; r++) begin
      for (int c = 0; c < T_C; c++) begin
        for (int k = 0; k < 5; k++) addr_q.push_back((r + DY[k]) * T_W + c + DX[k]);
        e.row = r;
        e.col = c;
        e.pix = int'(lap(img(r, c + 1), img(r + 1, c), img(r + 1, c + 1),
                         img(r + 1, c + 2), img(r + 2, c + 1)));
        pix_q.push_back(e);
      end
    end
  endtask

  task automatic fill_image(input int kind);
    for (int i = 0; i < IMG_WORDS; i++) begin
      case (kind)
        0:       mem[i] = 8'(i);
        1:       mem[i] = 8'(100);
        default: mem[i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic start_frame();
    push_frame();
    first_hs = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 200);
    if (!out_valid) bound_fail(name);
  endtask

  task automatic wait_done(input bit poke);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 4000 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (poke) start = ($urandom_range(0, 7) == 0);
    end
    if (!seen) begin
      start = 1'b0;
      bound_fail("wait_done");
      return;
    end
    exp_done++;
    start = 1'b1;          // ignored while in DONE
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_done", 64'(busy), 64'd0);
    check("done_count", 64'(done_cnt), 64'(exp_done));
    check("fetch_q_empty", 64'(addr_q.size()), 64'd0);
    check("pix_q_empty", 64'(pix_q.size()), 64'd0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (mon_en && !rst) begin
      if (mem_rd) begin
        if (addr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL fetch_extra: addr %0d fetched, none expected", mem_addr);
        end else begin
          check("fetch_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
        end
      end
      if (out_valid && out_ready) begin
        if (pix_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL pix_extra: (%0d,%0d) emitted, none expected", out_row, out_col);
        end else begin
          mon_e = pix_q.pop_front();
          check("out_row", 64'(out_row), 64'(mon_e.row));
          check("out_col", 64'(out_col), 64'(mon_e.col));
          check("out_pixel", 64'(out_pixel), 64'(mon_e.pix));
        end
        if (ready_mode == 0 && !first_hs) check("pixel_period", 64'(cyc - last_hs), 64'd8);
        last_hs  = cyc;
        first_hs = 1'b0;
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    logic [PIX_W-1:0] held;
    int n;
    rst   = 1'b1;
    start = 1'b1;
    ag_row = 9'd509;
    ag_col = 9'd509;
    ag_k   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst    = 1'b0;
    start  = 1'b0;
    mon_en = 1'b1;

    // Last full-frame pixel (509,509): all five addresses, incl. e and h bounds.
    for (int k = 0; k < 5; k++) begin
      ag_k = 3'(k);
      #1;
      check("agen_last", 64'(ag_addr), 64'((509 + DY[k]) * 512 + 509 + DX[k]));
    end
    ag_k = 3'd2;
    #1;
    check("agen_last_e", 64'(ag_addr), 64'd261630);
    ag_k = 3'd4;
    #1;
    check("agen_last_h", 64'(ag_addr), 64'd262142);

    // Ramp image, always ready: first-pixel window contents and 8-cycle cadence.
    fill_image(0);
    ready_mode = 0;
    start_frame();
    wait_valid("first_valid");
    check("first_win", 64'({win_b, win_d, win_e, win_f, win_h}),
          64'({8'd1, 8'd0, 8'd1, 8'd2, 8'd1}));
    check("first_coord", 64'({out_row, out_col}), 64'd0);
    wait_done(1'b0);

    // Random image: 20-cycle stall on the first result, then random backpressure and start pokes.
    fill_image(2);
    ready_mode = 2;
    start_frame();
    wait_valid("stall_valid");
    held = out_pixel;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_pixel", 64'(out_pixel), 64'(held));
      check("stall_no_fetch", 64'(mem_rd), 64'd0);
    end
    ready_mode = 1;
    wait_done(1'b1);

    // Constant image: every result is zero.
    fill_image(1);
    ready_mode = 0;
    start_frame();
    wait_done(1'b0);

    // Reset during FETCH of pixel (2,4), then a clean restart.
    fill_image(2);
    ready_mode = 1;
    start_frame();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_ready && out_row == 9'd2 && out_col == 9'd3) && n < 2000);
    if (n >= 2000) bound_fail("abort_wait");
    @(posedge clk);
    @(negedge clk);
    check("abort_in_fetch", 64'(mem_rd), 64'd1);
    mon_en = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("abort");
    rst = 1'b0;
    addr_q.delete();
    pix_q.delete();
    mon_en = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'(exp_done));
    check("abort_idle", 64'(busy), 64'd0);

    start_frame();
    n = 0;
    while (!mem_rd && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mem_rd) bound_fail("restart_fetch");
    else check("restart_first_addr", 64'(mem_addr), 64'd1);
    wait_done(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
